dmem_rmw_ctrl: RTL and testbench
================================

# dmem_rmw_ctrl

Load/store sequencer between the core's memory stage and a raw 32-bit word-wide 1R1W data memory (synchronous read, 1-cycle latency). Accepts one byte/half/word request at a time and produces a sign- or zero-extended load result. Sub-word stores become read-modify-write sequences so neighbouring bytes in the word are preserved. Misaligned and reserved-size requests are rejected with an error response and never touch memory.

## Interface
- MEM_DEPTH, 32, data memory depth in 32-bit words
- ADDR_W, $clog2(MEM_DEPTH)+2, byte address width
- clk  in  1  clock; single clock domain, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  controller can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
- req_size  in  3  [1:0]: 00 byte, 01 half, 10 word, 11 reserved; [2]: unsigned load
- resp_valid  out  1  response valid
- resp_ready  in  1  response consumer ready
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  misaligned or reserved-size request
- mem_rd_addr  out  ADDR_W  word-aligned read address ([1:0] = 0)
- mem_rd_dout  in  32  memory read data, valid the cycle after mem_rd_addr is presented
- mem_wr_addr  out  ADDR_W  word-aligned write address
- mem_wr_din  out  32  full merged word
- mem_we  out  1  write enable, one cycle per store

## Operation
- States: IDLE, RD, CAP, MRG, WR, RESP.
- IDLE: req_ready=1. On req_valid&req_ready, latch we/addr/wdata/size. Next state:
  - misaligned (half with addr[0]=1; word with addr[1:0]≠0) or size[1:0]=11: RESP, err=1
  - word store: WR
  - otherwise: RD
- RD: mem_rd_addr = {addr[ADDR_W-1:2],2'b00}. Next: CAP for loads, MRG for stores.
- CAP: register the result of shifting mem_rd_dout right by 8*addr[1:0], then extending (byte: bit 7, half: bit 15, word: none; zero-extend when size[2]=1). Next: RESP.
- MRG: register the merged word. Byte store replaces bits [8*addr[1:0]+:8] with wdata[7:0]. Half store replaces [16*addr[1]+:16] with wdata[15:0]. All other bits come from mem_rd_dout. Next: WR.
- WR: mem_we=1, mem_wr_addr word-aligned, mem_wr_din = merged word (wdata for a word store). Next: RESP.
- RESP: resp_valid=1 with registered rdata/err. Hold until resp_ready, then IDLE.
- size[2] is ignored for stores and for word loads.
- Reset: state=IDLE; req_ready=1; resp_valid=0, resp_rdata=0, resp_err=0; mem_we=0; mem_rd_addr=0, mem_wr_addr=0, mem_wr_din=0. mem_we is gated by ~rst, so no write occurs in any cycle where rst=1, including reset mid-WR. An in-flight transaction is dropped with no response.

## Timing
- T = accept cycle. resp_valid first asserts at:
  - load: T+3
  - byte/half store: T+4 (mem_we at T+3)
  - word store: T+2 (mem_we at T+1)
  - error: T+1
- Back-to-back: the next request can be accepted the cycle after RESP completes. A request held through RESP is accepted in the following IDLE cycle.
- resp_valid, resp_rdata and resp_err are stable while resp_valid=1 and resp_ready=0.
- Only one transaction is in flight, so no read-after-write hazard and no read/write port collision.
- No combinational path from req_* to resp_*. mem_rd_addr and mem_wr_* are decoded from registered state.

## Structure
- Package dmem_rmw_pkg:
  - size codes SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10
  - state encoding
  - misaligned-check function
- Sub-module dmem_lane_fmt (combinational): load shift/extend plus store merge, instantiated once. The FSM and registers stay in the top.

## Test plan
- Word store 0xDEADBEEF @0x08, then LW @0x08 → mem_we at T+1; resp_rdata=0xDEADBEEF at T+3, err=0.
- Memory word @0x04 = 0x11223344; SB 0xAA @0x05 → mem_wr_din=0x1122AA44. Then LBU @0x05 → 0x000000AA; LB @0x05 → 0xFFFFFFAA.
- SH 0x8001 @0x06 on word 0x11223344 → 0x80013344. LH @0x06 → 0xFFFF8001; LHU → 0x00008001.
- LW @0x02, SH @0x03, size=2'b11 @0x00 → each gives resp_err=1 at T+1, resp_rdata=0, mem_we never asserted.
- resp_ready held low for 5 cycles in RESP → resp_valid and data stable, req_ready=0 throughout. Release → IDLE next cycle, new request accepted.
- rst asserted during WR of SB @0x05 → no mem_we, word unchanged. The cycle after rst deasserts: req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared size codes, FSM encoding and request decode helpers for the
// data-memory load/store sequencer.
package dmem_rmw_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_CAP  = 3'd2;
    localparam logic [2:0] ST_MRG  = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] ST_RESP = 3'd5;

    // Request fields held for the whole transaction (address kept separately,
    // its width is a module parameter).
    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_lat_t;

    // Misaligned access or reserved size code: answered with an error, no memory traffic.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return addr_lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_rmw_ctrl_if.sv
// Request/response handshake plus raw 1R1W memory port of the sequencer.
interface dmem_rmw_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_size;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_rd_addr;
    logic [31:0]       mem_rd_dout;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [31:0]       mem_wr_din;
    logic              mem_we;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, resp_ready, mem_rd_dout,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, resp_ready, mem_rd_dout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_rd_addr, mem_wr_addr, mem_wr_din, mem_we
    );
endinterface

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting: load shift/extend and sub-word store merge into the
// word read back from memory.
module dmem_lane_fmt
    import dmem_rmw_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  size,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);
    logic [31:0] shifted;

    assign shifted = rd_word >> {addr_lo, 3'b000};

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        load_data  = shifted;
        merge_data = rd_word;
        case (size[1:0])
            SZ_BYTE: begin
                load_data = {{24{shifted[7] & ~size[2]}}, shifted[7:0]};
                merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
            end
            SZ_HALF: begin
                load_data = {{16{shifted[15] & ~size[2]}}, shifted[15:0]};
                merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
            end
            SZ_WORD: merge_data = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Single-outstanding load/store sequencer; sub-word stores become
// read-modify-write so neighbouring bytes survive.
module dmem_rmw_ctrl
    import dmem_rmw_pkg::*;
#(
    parameter int MEM_DEPTH = 32,
    parameter int ADDR_W    = $clog2(MEM_DEPTH) + 2
) (
    input  logic            clk,
    input  logic            rst,
    dmem_rmw_ctrl_if.slave  bus
);
    logic [2:0]        state_q;
    logic [2:0]        state_d;
    req_lat_t          req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       merged_q;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;
    logic              accept;
    logic              bad_req;

    assign accept  = bus.req_valid && (state_q == ST_IDLE);
    assign bad_req = req_is_bad(bus.req_size[1:0], bus.req_addr[1:0]);

    dmem_lane_fmt u_lane_fmt (
        .addr_lo    (addr_q[1:0]),
        .size       (req_q.size),
        .rd_word    (bus.mem_rd_dout),
        .wdata      (req_q.wdata),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_req)
                        state_d = ST_RESP;
                    else if (bus.req_we && bus.req_size[1:0] == SZ_WORD)
                        state_d = ST_WR;
                    else
                        state_d = ST_RD;
                end
            end
            ST_RD:   state_d = req_q.we ? ST_MRG : ST_CAP;
            ST_CAP:  state_d = ST_RESP;
            ST_MRG:  state_d = ST_WR;
            ST_WR:   state_d = ST_RESP;
            ST_RESP: if (bus.resp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only the controller's own registers are reset; the data
            // memory behind the port keeps its contents across reset.
            state_q  <= ST_IDLE;
            req_q    <= '0;
            addr_q   <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            merged_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                req_q    <= '{we: bus.req_we, size: bus.req_size, wdata: bus.req_wdata};
                addr_q   <= bus.req_addr;
                err_q    <= bad_req;
                rdata_q  <= '0;
                merged_q <= bus.req_wdata;  // already final for a word store
            end
            if (state_q == ST_CAP) rdata_q  <= load_data;
            if (state_q == ST_MRG) merged_q <= merge_data;
        end
    end

    assign bus.req_ready   = (state_q == ST_IDLE);
    assign bus.resp_valid  = (state_q == ST_RESP);
    assign bus.resp_rdata  = rdata_q;
    assign bus.resp_err    = err_q;
    assign bus.mem_rd_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wr_addr = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wr_din  = merged_q;
    // Gated by rst so a reset landing in WR cannot corrupt the word.
    assign bus.mem_we      = (state_q == ST_WR) && !rst;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Directed self-checking bench for dmem_rmw_ctrl with a behavioural 1R1W memory
// and a scoreboard of expected responses.
module tb_dmem_rmw_ctrl;
    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 7;
    localparam int MAX_WAIT  = 20;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dmem_rmw_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    dmem_rmw_ctrl #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_W    (ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [MEM_DEPTH];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_wr_addr[ADDR_W-1:2]] <= bus.mem_wr_din;
        bus.mem_rd_dout <= mem[bus.mem_rd_addr[ADDR_W-1:2]];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          we_k;   // cycle offset of the write strobe, 0 = no write
        logic [31:0] din;
        logic [31:0] waddr;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one request in the next IDLE cycle and check its response; hold > 0
    // keeps resp_ready low for that many RESP cycles.
    task automatic xact(input string tag, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [31:0] wdata, input logic [2:0] size,
                        input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat,
                        input int exp_we_k, input logic [31:0] exp_din, input int hold);
        exp_t        e;
        exp_t        got;
        int          lat;
        int          we_k;
        int          we_n;
        logic [31:0] din;
        logic [31:0] waddr;

        @(negedge clk);
        check({tag, " req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_size   = size;
        bus.resp_ready = (hold == 0);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.lat   = exp_lat;
        e.we_k  = exp_we_k;
        e.din   = exp_din;
        e.waddr = {25'd0, addr[ADDR_W-1:2], 2'b00};
        sb.push_back(e);

        lat = 0; we_k = 0; we_n = 0; din = '0; waddr = '0;
        for (int k = 1; k <= MAX_WAIT; k++) begin
            @(negedge clk);
            if (k == 1) bus.req_valid = 1'b0;
            if (bus.mem_we) begin
                we_n++;
                we_k  = k;
                din   = bus.mem_wr_din;
                waddr = 32'(bus.mem_wr_addr);
            end
            if (bus.resp_valid) begin
                lat = k;
                break;
            end
        end

        got = sb.pop_front();
        check({tag, " latency"}, 32'(lat), 32'(got.lat));
        check({tag, " rdata"}, bus.resp_rdata, got.rdata);
        check({tag, " err"}, 32'(bus.resp_err), 32'(got.err));
        check({tag, " we_count"}, 32'(we_n), (got.we_k != 0) ? 32'd1 : 32'd0);
        if (got.we_k != 0) begin
            check({tag, " we_cycle"}, 32'(we_k), 32'(got.we_k));
            check({tag, " wr_din"}, din, got.din);
            check({tag, " wr_addr"}, waddr, got.waddr);
        end

        if (hold > 0) begin
            for (int i = 1; i < hold; i++) begin
                @(negedge clk);
                check({tag, " stall valid"}, 32'(bus.resp_valid), 32'd1);
                check({tag, " stall rdata"}, bus.resp_rdata, got.rdata);
                check({tag, " stall err"}, 32'(bus.resp_err), 32'(got.err));
                check({tag, " stall req_ready"}, 32'(bus.req_ready), 32'd0);
            end
            bus.resp_ready = 1'b1;
            @(negedge clk);
            check({tag, " release valid"}, 32'(bus.resp_valid), 32'd0);
            check({tag, " release req_ready"}, 32'(bus.req_ready), 32'd1);
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] = '0;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_size   = '0;
        bus.resp_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready), 32'd1);
        check("reset resp_valid", 32'(bus.resp_valid), 32'd0);
        check("reset resp_rdata", bus.resp_rdata, 32'd0);
        check("reset resp_err", 32'(bus.resp_err), 32'd0);
        check("reset mem_we", 32'(bus.mem_we), 32'd0);
        check("reset mem_rd_addr", 32'(bus.mem_rd_addr), 32'd0);
        check("reset mem_wr_addr", 32'(bus.mem_wr_addr), 32'd0);
        check("reset mem_wr_din", bus.mem_wr_din, 32'd0);
        rst = 1'b0;

        //   tag     we    addr   wdata          size     rdata          err  lat we_k din           hold
        xact("sw8",  1'b1, 7'h08, 32'hDEADBEEF, 3'b010, 32'h0,         1'b0, 2, 1, 32'hDEADBEEF, 0);
        xact("lw8",  1'b0, 7'h08, 32'h0,        3'b010, 32'hDEADBEEF,  1'b0, 3, 0, 32'h0,        0);
        xact("sw4",  1'b1, 7'h04, 32'h11223344, 3'b010, 32'h0,         1'b0, 2, 1, 32'h11223344, 0);
        xact("sb5",  1'b1, 7'h05, 32'h000000AA, 3'b000, 32'h0,         1'b0, 4, 3, 32'h1122AA44, 0);
        xact("lbu5", 1'b0, 7'h05, 32'h0,        3'b100, 32'h000000AA,  1'b0, 3, 0, 32'h0,        0);
        xact("lb5",  1'b0, 7'h05, 32'h0,        3'b000, 32'hFFFFFFAA,  1'b0, 3, 0, 32'h0,        0);
        xact("lw4a", 1'b0, 7'h04, 32'h0,        3'b010, 32'h1122AA44,  1'b0, 3, 0, 32'h0,        0);
        xact("sw4b", 1'b1, 7'h04, 32'h11223344, 3'b010, 32'h0,         1'b0, 2, 1, 32'h11223344, 0);
        xact("sh6",  1'b1, 7'h06, 32'h00008001, 3'b001, 32'h0,         1'b0, 4, 3, 32'h80013344, 0);
        xact("lh6",  1'b0, 7'h06, 32'h0,        3'b001, 32'hFFFF8001,  1'b0, 3, 0, 32'h0,        0);
        xact("lhu6", 1'b0, 7'h06, 32'h0,        3'b101, 32'h00008001,  1'b0, 3, 0, 32'h0,        0);
        xact("lb7",  1'b0, 7'h07, 32'h0,        3'b000, 32'hFFFFFF80,  1'b0, 3, 0, 32'h0,        0);
        xact("lbu4", 1'b0, 7'h04, 32'h0,        3'b100, 32'h00000044,  1'b0, 3, 0, 32'h0,        0);
        xact("lh4",  1'b0, 7'h04, 32'h0,        3'b001, 32'h00003344,  1'b0, 3, 0, 32'h0,        0);
        // upper wdata bits and size[2] must not leak into a byte store
        xact("sb4",  1'b1, 7'h04, 32'hFFFFFF7F, 3'b100, 32'h0,         1'b0, 4, 3, 32'h8001337F, 0);
        xact("lw4b", 1'b0, 7'h04, 32'h0,        3'b110, 32'h8001337F,  1'b0, 3, 0, 32'h0,        0);
        xact("elw2", 1'b0, 7'h02, 32'h0,        3'b010, 32'h0,         1'b1, 1, 0, 32'h0,        0);
        xact("esh3", 1'b1, 7'h03, 32'h0000FFFF, 3'b001, 32'h0,         1'b1, 1, 0, 32'h0,        0);
        xact("ersv", 1'b0, 7'h00, 32'h0,        3'b011, 32'h0,         1'b1, 1, 0, 32'h0,        0);
        xact("esw6", 1'b1, 7'h06, 32'h12345678, 3'b010, 32'h0,         1'b1, 1, 0, 32'h0,        0);
        xact("ersw", 1'b1, 7'h00, 32'h12345678, 3'b111, 32'h0,         1'b1, 1, 0, 32'h0,        0);
        xact("lw4c", 1'b0, 7'h04, 32'h0,        3'b010, 32'h8001337F,  1'b0, 3, 0, 32'h0,        0);
        xact("hold", 1'b0, 7'h08, 32'h0,        3'b010, 32'hDEADBEEF,  1'b0, 3, 0, 32'h0,        5);
        xact("sw4c", 1'b1, 7'h04, 32'h11223344, 3'b010, 32'h0,         1'b0, 2, 1, 32'h11223344, 0);

        // Reset lands in the WR cycle of a byte store: the write must be suppressed.
        @(negedge clk);
        check("rstwr req_ready", 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 7'h05;
        bus.req_wdata = 32'h000000AA;
        bus.req_size  = 3'b000;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rstwr in WR", 32'(bus.mem_we), 32'd1);
        rst = 1'b1;
        #1;
        check("rstwr mem_we gated", 32'(bus.mem_we), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rstwr after req_ready", 32'(bus.req_ready), 32'd1);
        check("rstwr after resp_valid", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        check("rstwr idle resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rstwr mem word", mem[1], 32'h11223344);
        xact("lw4d", 1'b0, 7'h04, 32'h0,        3'b010, 32'h11223344,  1'b0, 3, 0, 32'h0,        0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
